// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: default addresses,
// status bit positions and serializer state encodings.
package mmio_uart_tx_pkg;

  localparam logic [7:0] TX_ADDR_DEF     = 8'hFF;
  localparam logic [7:0] STATUS_ADDR_DEF = 8'hFE;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_COUNT_LSB = 4;

  // IDLE line high | START start bit | DATA 8 bits LSB first | STOP stop bit, may chain
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  function automatic logic [3:0] sat_count4(input logic [31:0] c);
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with combinational read data at the head and an occupancy count.
module mmio_uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Console responder on the data-memory bus: stores queue bytes for an 8N1 serializer,
// loads of the status address return FIFO/serializer state one cycle later.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] TX_ADDR      = TX_ADDR_DEF,
  parameter logic [7:0] STATUS_ADDR  = STATUS_ADDR_DEF
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [7:0]  ADDR,
  input  logic [31:0] DIN,
  input  logic        wren,
  output logic [31:0] DOUT,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [1:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          overflow;

  logic          push_req, stat_wr, push, pop, ovf_set, baud_end;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    status;
  logic          unused_din;

  assign unused_din = ^DIN[31:8];

  assign push_req = wren && (ADDR == TX_ADDR);
  assign stat_wr  = wren && (ADDR == STATUS_ADDR);
  assign baud_end = (baud == BAUD_LAST);
  // A pop frees a slot in the same edge, so a push into a full FIFO still lands.
  assign pop      = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && baud_end));
  assign push     = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && !push;
  assign busy     = !fifo_empty || (state != S_IDLE);

  mmio_uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (DIN[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status = '0;
    status[ST_EMPTY_BIT] = fifo_empty;
    status[ST_FULL_BIT]  = fifo_full;
    status[ST_BUSY_BIT]  = busy;
    status[ST_OVF_BIT]   = overflow;
    status[ST_COUNT_LSB +: 4] = sat_count4(32'(fifo_count));
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      DOUT     <= '0;
      hit      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      hit  <= (ADDR == TX_ADDR) || (ADDR == STATUS_ADDR);
      DOUT <= (ADDR == STATUS_ADDR) ? {24'b0, status} : '0;
      if (ovf_set)      overflow <= 1'b1;
      else if (stat_wr) overflow <= 1'b0;
    end
  end

  // tx follows the state present before the edge, giving one cycle from pop to start bit.
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      tx   <= (state == S_START) ? 1'b0 : (state == S_DATA) ? shift[0] : 1'b1;
      baud <= ((state == S_IDLE) || baud_end) ? '0 : baud + BW'(1);
      case (state)
        S_IDLE: begin
          if (pop) begin
            shift <= fifo_rdata;
            state <= S_START;
          end
        end
        S_START: begin
          if (baud_end) begin
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            if (pop) begin
              shift <= fifo_rdata;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: bus vector table, cycle-exact frame sequences and a UART receiver model.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [7:0]  ADDR  = 8'h10;
  logic [31:0] DIN   = 32'h0;
  logic        wren  = 1'b0;
  logic [31:0] DOUT;
  logic        hit, tx, busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int rx_ferr = 0;

  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  logic [7:0] exp_q[$];

  logic fbits [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] din;
    logic        wr;
    logic [31:0] exp_dout;
    logic        exp_hit;
  } vec_t;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (8'hFF),
    .STATUS_ADDR  (8'hFE)
  ) dut (
    .clock (clock),
    .clear (clear),
    .ADDR  (ADDR),
    .DIN   (DIN),
    .wren  (wren),
    .DOUT  (DOUT),
    .hit   (hit),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus(input logic [7:0] a, input logic [31:0] d, input logic w);
    ADDR = a;
    DIN  = d;
    wren = w;
    tick();
    ADDR = 8'h10;
    DIN  = 32'h0;
    wren = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'h0);
    repeat (6) tick();
  endtask

  task automatic check_rx(input string name);
    check({name, " count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    rx_cyc.delete();
    exp_q.delete();
  endtask

  // Receiver samples mid-bit on falling clock edges; a frame touched by clear is discarded.
  initial begin : rx_model
    logic [7:0] d;
    logic       ab, err;
    int         t0;
    forever begin
      @(negedge tx);
      d = '0; ab = 1'b0; err = 1'b0; t0 = 0;
      for (int k = 0; k < 38; k++) begin
        @(negedge clock);
        if (k == 0) t0 = cyc;
        if (clear) ab = 1'b1;
        if (k == 1 && tx !== 1'b0) err = 1'b1;
        if (k >= 5 && k <= 33 && ((k - 5) % 4) == 0) d[(k - 5) / 4] = tx;
        if (k == 37 && tx !== 1'b1) err = 1'b1;
      end
      if (!ab) begin
        rx_q.push_back(d);
        rx_cyc.push_back(t0);
        if (err) rx_ferr++;
      end
    end
  end

  initial begin : main
    vec_t vecs [7];
    logic busy_e40;

    vecs[0] = '{8'hFE, 32'h0,        1'b0, 32'h1, 1'b1};
    vecs[1] = '{8'h10, 32'h0,        1'b0, 32'h0, 1'b0};
    vecs[2] = '{8'hFF, 32'h0000_00AA, 1'b0, 32'h0, 1'b1};
    vecs[3] = '{8'hFE, 32'h0,        1'b0, 32'h1, 1'b1};
    vecs[4] = '{8'hFD, 32'h0,        1'b0, 32'h0, 1'b0};
    vecs[5] = '{8'hFE, 32'hFFFF_FFFF, 1'b1, 32'h1, 1'b1};
    vecs[6] = '{8'h00, 32'h0,        1'b0, 32'h0, 1'b0};

    // Reset
    clear = 1'b1;
    tick();
    tick();
    check("rst tx",   32'(tx),   32'h1);
    check("rst busy", 32'(busy), 32'h0);
    check("rst dout", DOUT,      32'h0);
    check("rst hit",  32'(hit),  32'h0);
    clear = 1'b0;

    for (int i = 0; i < 7; i++) begin
      bus(vecs[i].addr, vecs[i].din, vecs[i].wr);
      check($sformatf("vec%0d dout", i), DOUT, vecs[i].exp_dout);
      check($sformatf("vec%0d hit", i), 32'(hit), 32'(vecs[i].exp_hit));
    end

    // Single frame, cycle-exact
    bus(8'hFF, 32'hABCD_1241, 1'b1);
    check("t2 tx push edge", 32'(tx), 32'h1);
    tick();
    check("t2 tx pop edge", 32'(tx), 32'h1);
    check("t2 busy", 32'(busy), 32'h1);
    busy_e40 = 1'b0;
    for (int b = 0; b < 10; b++) begin
      int bad = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (tx !== fbits[b]) bad++;
        if (b == 9 && c == 2) busy_e40 = busy;
      end
      check($sformatf("t2 bit%0d errors", b), 32'(bad), 32'h0);
    end
    check("t2 busy in stop", 32'(busy_e40), 32'h1);
    check("t2 busy after stop", 32'(busy), 32'h0);
    drain("t2 drain");
    exp_q.push_back(8'h41);
    check_rx("t2 rx");

    // Six back-to-back stores, sixth overflows
    for (int i = 0; i < 6; i++) begin
      bus(8'hFF, 32'h1234_5600 | 32'(65 + i), 1'b1);
      if (i < 5) exp_q.push_back(8'(65 + i));
    end
    bus(8'hFE, 32'h0, 1'b0);
    check("t3 status", DOUT, 32'h4E);
    check("t3 hit", 32'(hit), 32'h1);

    // Clearing overflow leaves FIFO state alone
    bus(8'hFE, 32'h0, 1'b1);
    bus(8'hFE, 32'h0, 1'b0);
    check("t4 status", DOUT, 32'h46);
    drain("t3 drain");
    for (int i = 1; i < rx_cyc.size(); i++)
      check($sformatf("t3 frame gap%0d", i), 32'(rx_cyc[i] - rx_cyc[i-1]), 32'd40);
    check_rx("t3 rx");
    bus(8'hFE, 32'h0, 1'b0);
    check("t4 status idle", DOUT, 32'h1);

    // Push into a full FIFO on the edge the stop bit ends
    for (int i = 0; i < 5; i++) begin
      bus(8'hFF, 32'(8'h30 + i), 1'b1);
      exp_q.push_back(8'(8'h30 + i));
    end
    repeat (36) tick();
    bus(8'hFF, 32'h0000_0035, 1'b1);
    exp_q.push_back(8'h35);
    bus(8'hFE, 32'h0, 1'b0);
    check("t5 status", DOUT, 32'h46);
    drain("t5 drain");
    check_rx("t5 rx");

    // Reset in the middle of data bit 3
    bus(8'hFF, 32'h0000_0041, 1'b1);
    repeat (18) tick();
    check("t6 tx bit3", 32'(tx), 32'h0);
    clear = 1'b1;
    ADDR  = 8'hFE;
    tick();
    check("t6 tx", 32'(tx), 32'h1);
    check("t6 busy", 32'(busy), 32'h0);
    check("t6 dout", DOUT, 32'h0);
    check("t6 hit", 32'(hit), 32'h0);
    clear = 1'b0;
    ADDR  = 8'h10;
    bus(8'hFE, 32'h0, 1'b0);
    check("t6 status", DOUT, 32'h1);
    repeat (30) tick();
    check_rx("t6 aborted rx");
    bus(8'hFF, 32'h0000_005A, 1'b1);
    exp_q.push_back(8'h5A);
    drain("t6 drain");
    check_rx("t6 rx");

    check("rx framing errors", 32'(rx_ferr), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
